// File: rtl/adder_round_seg_if.sv
// Handshake and operand/result bundle for the segmented rounding adder.
// The master drives the request side; the slave (the adder) returns status and result.
interface adder_round_seg_if #(
  parameter int SW = 26
);
  logic          start_i;
  logic [SW-1:0] Data_A_i;
  logic [SW-1:0] Data_B_i;
  logic [1:0]    round_mode_i;
  logic          sign_i;
  logic          guard_i;
  logic          sticky_i;
  logic          ready_o;
  logic          done_o;
  logic [SW-1:0] Data_Result_o;
  logic          FSM_C_o;

  modport master (
    output start_i, Data_A_i, Data_B_i, round_mode_i, sign_i, guard_i, sticky_i,
    input  ready_o, done_o, Data_Result_o, FSM_C_o
  );

  modport slave (
    input  start_i, Data_A_i, Data_B_i, round_mode_i, sign_i, guard_i, sticky_i,
    output ready_o, done_o, Data_Result_o, FSM_C_o
  );
endinterface

// File: rtl/adder_round_seg.sv
// Multi-cycle rounding adder: A + B + rnd_inc, SEG bits per cycle, with the
// SW-bit sum and carry-out registered and a start/ready/done handshake.
module adder_round_seg #(
  parameter int SW  = 26,
  parameter int SEG = 8
) (
  input  logic              clk,
  input  logic              rst,
  adder_round_seg_if.slave  bus
);
  localparam int NSEG = (SW + SEG - 1) / SEG;
  localparam int TOPW = SW - (NSEG - 1) * SEG;
  localparam int CW   = (NSEG > 1) ? $clog2(NSEG) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q;
  logic [SW-1:0] a_q, b_q, acc_q, res_q;
  logic          carry_q, c_q;
  logic [CW-1:0] seg_q;

  logic          rnd_inc_d;
  logic [31:0]   off_d;
  logic [SEG-1:0] a_seg_d, b_seg_d;
  logic [SEG:0]  seg_sum_d;
  logic          seg_cout_d;
  logic          last_d;
  logic [SW-1:0] acc_d;

  always_comb begin
    rnd_inc_d = 1'b0;
    case (bus.round_mode_i)
      2'b00:   rnd_inc_d = 1'b0;
      2'b01:   rnd_inc_d = bus.guard_i & (bus.sticky_i | bus.Data_A_i[0]);
      2'b10:   rnd_inc_d = ~bus.sign_i & (bus.guard_i | bus.sticky_i);
      default: rnd_inc_d =  bus.sign_i & (bus.guard_i | bus.sticky_i);
    endcase
  end

  // The top segment may be narrower than SEG: its carry-out sits at bit TOPW,
  // and sum bits above SW-1 fall off when shifted into the accumulator.
  always_comb begin
    off_d      = 32'(seg_q) * 32'(SEG);
    a_seg_d    = SEG'(a_q >> off_d);
    b_seg_d    = SEG'(b_q >> off_d);
    last_d     = (seg_q == CW'(NSEG - 1));
    seg_sum_d  = {1'b0, a_seg_d} + {1'b0, b_seg_d} + {{SEG{1'b0}}, carry_q};
    seg_cout_d = last_d ? seg_sum_d[TOPW] : seg_sum_d[SEG];
    acc_d      = acc_q | (SW'(seg_sum_d[SEG-1:0]) << off_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      c_q     <= 1'b0;
      seg_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            a_q     <= bus.Data_A_i;
            b_q     <= bus.Data_B_i;
            carry_q <= rnd_inc_d;
            acc_q   <= '0;
            seg_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q   <= acc_d;
          carry_q <= seg_cout_d;
          seg_q   <= seg_q + 1'b1;
          if (last_d) begin
            res_q   <= acc_d;
            c_q     <= seg_cout_d;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ready_o       = (state_q == IDLE);
  assign bus.done_o        = (state_q == DONE);
  assign bus.Data_Result_o = res_q;
  assign bus.FSM_C_o       = c_q;
endmodule

// File: tb/tb_adder_round_seg.sv
// Scoreboard bench for adder_round_seg: SEG=8 and SEG=SW instances driven with
// directed vectors; monitors pop expected results whenever done_o is seen.
module tb_adder_round_seg;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  adder_round_seg_if #(.SW(26)) bus0 ();
  adder_round_seg_if #(.SW(26)) bus1 ();

  adder_round_seg #(.SW(26), .SEG(8))  u0 (.clk(clk), .rst(rst), .bus(bus0));
  adder_round_seg #(.SW(26), .SEG(26)) u1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic [25:0] res;
    logic        c;
    int unsigned acc_cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1, ep;
  int n_chk  = 0;
  int n_fail = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus0.done_o) begin
      if (q0.size() == 0) chk("u0_spurious_done", 1, 0);
      else begin
        e0 = q0.pop_front();
        chk("u0_result",  bus0.Data_Result_o, e0.res);
        chk("u0_carry",   bus0.FSM_C_o, e0.c);
        chk("u0_latency", cyc - e0.acc_cyc, 4);
      end
    end
  end

  always @(negedge clk) begin
    if (bus1.done_o) begin
      if (q1.size() == 0) chk("u1_spurious_done", 1, 0);
      else begin
        e1 = q1.pop_front();
        chk("u1_result",  bus1.Data_Result_o, e1.res);
        chk("u1_carry",   bus1.FSM_C_o, e1.c);
        chk("u1_latency", cyc - e1.acc_cyc, 1);
      end
    end
  end

  task automatic set_in(input int sel, input logic st, input logic [25:0] a, input logic [25:0] b,
                        input logic [1:0] m, input logic sg, input logic g, input logic sk);
    if (sel == 0) begin
      bus0.start_i = st; bus0.Data_A_i = a; bus0.Data_B_i = b;
      bus0.round_mode_i = m; bus0.sign_i = sg; bus0.guard_i = g; bus0.sticky_i = sk;
    end else begin
      bus1.start_i = st; bus1.Data_A_i = a; bus1.Data_B_i = b;
      bus1.round_mode_i = m; bus1.sign_i = sg; bus1.guard_i = g; bus1.sticky_i = sk;
    end
  endtask

  task automatic push_exp(input int sel, input logic [25:0] r, input logic c);
    ep.res = r; ep.c = c; ep.acc_cyc = cyc;
    if (sel == 0) q0.push_back(ep); else q1.push_back(ep);
  endtask

  task automatic wait_ready(input int sel);
    int t;
    t = 0;
    @(negedge clk);
    while (!(sel == 0 ? bus0.ready_o : bus1.ready_o) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("ready_timeout", (t >= 50), 0);
  endtask

  task automatic wait_done(input int sel);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(sel == 0 ? bus0.done_o : bus1.done_o) && t < 50);
    chk("done_timeout", (t >= 50), 0);
  endtask

  task automatic run_op(input int sel, input logic [25:0] a, input logic [25:0] b,
                        input logic [1:0] m, input logic sg, input logic g, input logic sk,
                        input logic [25:0] er, input logic ec);
    wait_ready(sel);
    set_in(sel, 1'b1, a, b, m, sg, g, sk);
    @(posedge clk); #1;
    push_exp(sel, er, ec);
    if (sel == 0) bus0.start_i = 1'b0; else bus1.start_i = 1'b0;
    wait_done(sel);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    set_in(0, 1'b0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
    set_in(1, 1'b0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
    #12;
    chk("rst_ready0",  bus0.ready_o, 1);
    chk("rst_done0",   bus0.done_o, 0);
    chk("rst_result0", bus0.Data_Result_o, 0);
    chk("rst_carry0",  bus0.FSM_C_o, 0);
    chk("rst_ready1",  bus1.ready_o, 1);
    @(negedge clk);
    rst = 1'b1;

    // Overflow, rounding modes and segment-boundary carries.
    run_op(0, 26'h3FFFFFF, 26'h0000001, 2'b00, 1'b0, 1'b0, 1'b0, 26'h0000000, 1'b1);
    run_op(0, 26'h0000100, 26'h0000000, 2'b01, 1'b0, 1'b1, 1'b0, 26'h0000100, 1'b0);
    run_op(0, 26'h0000101, 26'h0000000, 2'b01, 1'b0, 1'b1, 1'b0, 26'h0000102, 1'b0);
    run_op(0, 26'h0000200, 26'h0000005, 2'b01, 1'b0, 1'b1, 1'b1, 26'h0000206, 1'b0);
    run_op(0, 26'h0001000, 26'h0000FFF, 2'b10, 1'b1, 1'b1, 1'b0, 26'h0001FFF, 1'b0);
    run_op(0, 26'h0001000, 26'h0000FFF, 2'b11, 1'b1, 1'b1, 1'b0, 26'h0002000, 1'b0);
    run_op(0, 26'h3FFFFFF, 26'h3FFFFFF, 2'b10, 1'b0, 1'b1, 1'b0, 26'h3FFFFFF, 1'b1);
    run_op(0, 26'h0123456, 26'h0111111, 2'b00, 1'b1, 1'b1, 1'b1, 26'h0234567, 1'b0);
    run_op(0, 26'h00000FF, 26'h0000001, 2'b00, 1'b0, 1'b0, 1'b0, 26'h0000100, 1'b0);

    // start_i held high: only accept-edge operands count; re-accept two edges after done.
    wait_ready(0);
    set_in(0, 1'b1, 26'h0000010, 26'h0000020, 2'b00, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    push_exp(0, 26'h0000030, 1'b0);
    chk("hold_accepted", bus0.ready_o, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus0.Data_A_i = 26'($urandom);
      bus0.Data_B_i = 26'($urandom);
      bus0.round_mode_i = 2'b10;
      bus0.guard_i = 1'b1;
    end
    wait_done(0);
    set_in(0, 1'b1, 26'h0000001, 26'h0000002, 2'b00, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("hold_idle_after_done", bus0.ready_o, 1);
    @(posedge clk); #1;
    push_exp(0, 26'h0000003, 1'b0);
    chk("hold_reaccepted", bus0.ready_o, 0);
    bus0.start_i = 1'b0;
    wait_done(0);

    // Reset during CALC segment 2 aborts the op and clears outputs.
    wait_ready(0);
    set_in(0, 1'b1, 26'h3FFFFFF, 26'h0000001, 2'b00, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus0.start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_result", bus0.Data_Result_o, 0);
    chk("abort_carry",  bus0.FSM_C_o, 0);
    chk("abort_ready",  bus0.ready_o, 1);
    chk("abort_done",   bus0.done_o, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    run_op(0, 26'h00000FF, 26'h0000001, 2'b00, 1'b0, 1'b0, 1'b0, 26'h0000100, 1'b0);

    // SEG = SW: single CALC cycle.
    run_op(1, 26'h2AAAAAA, 26'h1555555, 2'b00, 1'b0, 1'b0, 1'b0, 26'h3FFFFFF, 1'b0);
    run_op(1, 26'h3FFFFFF, 26'h3FFFFFF, 2'b01, 1'b0, 1'b1, 1'b1, 26'h3FFFFFF, 1'b1);
    run_op(1, 26'h0000101, 26'h0000000, 2'b01, 1'b0, 1'b1, 1'b0, 26'h0000102, 1'b0);

    repeat (5) @(negedge clk);
    chk("u0_queue_drained", q0.size(), 0);
    chk("u1_queue_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
